// File: rtl/lan_act_blink.sv
// Per-port LAN activity LED blinker on the 32.768 kHz domain.
// Build option LAN_ACT_LINK_STEADY_EN: LED steady on while linked; otherwise lit only in the blink-on phase.
module lan_act_blink #(
  parameter int PORTS      = 2,
  parameter int BLINK_HALF = 1024,
  parameter int CW         = 10
) (
  input  logic             CLK32768,
  input  logic             RST_N,
  input  logic             ALL_PWRGD,
  input  logic [PORTS-1:0] RActivity,
  input  logic [PORTS-1:0] Speed1R,
  input  logic [PORTS-1:0] Speed2R,
  output logic [PORTS-1:0] ActLED_N
);

  // state     | meaning
  // OFF       | no power-good or no link, LED dark
  // IDLE      | linked, no pending traffic
  // BLINK_OFF | dark half-period of a blink
  // BLINK_ON  | lit half-period of a blink
  typedef enum logic [1:0] {
    ST_OFF,
    ST_IDLE,
    ST_BLINK_OFF,
    ST_BLINK_ON
  } state_t;

`ifdef LAN_ACT_LINK_STEADY_EN
  localparam logic IDLE_LED_N = 1'b0;
`else
  localparam logic IDLE_LED_N = 1'b1;
`endif

  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF - 1);

  logic [PORTS-1:0] act_s1, act_s2, act_s3;
  logic [PORTS-1:0] spd1_s1, spd1_s2, spd2_s1, spd2_s2;
  logic [PORTS-1:0] link, act_evt;
  logic [CW-1:0]    cnt_q;
  logic             tick;
  state_t           state_q [PORTS];
  state_t           state_d [PORTS];
  logic [PORTS-1:0] pend_q, pend_d, led_d;

  // Synchronizers reset high so release never looks like an event or a link.
  always_ff @(posedge CLK32768 or negedge RST_N) begin
    if (!RST_N) begin
      act_s1  <= '1;
      act_s2  <= '1;
      act_s3  <= '1;
      spd1_s1 <= '1;
      spd1_s2 <= '1;
      spd2_s1 <= '1;
      spd2_s2 <= '1;
    end else begin
      act_s1  <= RActivity;
      act_s2  <= act_s1;
      act_s3  <= act_s2;
      spd1_s1 <= Speed1R;
      spd1_s2 <= spd1_s1;
      spd2_s1 <= Speed2R;
      spd2_s2 <= spd2_s1;
    end
  end

  assign link    = ~(spd1_s2 & spd2_s2);
  assign act_evt = act_s3 & ~act_s2;
  assign tick    = (cnt_q == CNT_LAST);

  always_ff @(posedge CLK32768 or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= tick ? '0 : cnt_q + CW'(1);
  end

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      state_d[i] = state_q[i];
      pend_d[i]  = pend_q[i];
      led_d[i]   = 1'b1;
      if (!ALL_PWRGD || !link[i]) begin
        state_d[i] = ST_OFF;
        pend_d[i]  = 1'b0;
      end else begin
        case (state_q[i])
          ST_OFF:       state_d[i] = ST_IDLE;
          ST_IDLE:      if (tick && pend_q[i]) state_d[i] = ST_BLINK_OFF;
          ST_BLINK_OFF: if (tick) state_d[i] = ST_BLINK_ON;
          ST_BLINK_ON:  if (tick) state_d[i] = pend_q[i] ? ST_BLINK_OFF : ST_IDLE;
          default:      state_d[i] = ST_OFF;
        endcase
        // An event landing on the same tick that starts a dark phase survives.
        if (state_d[i] == ST_BLINK_OFF && state_q[i] != ST_BLINK_OFF) pend_d[i] = 1'b0;
        if (act_evt[i]) pend_d[i] = 1'b1;
      end
      case (state_q[i])
        ST_IDLE:     led_d[i] = IDLE_LED_N;
        ST_BLINK_ON: led_d[i] = 1'b0;
        default:     led_d[i] = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK32768 or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < PORTS; i++) state_q[i] <= ST_OFF;
      pend_q   <= '0;
      ActLED_N <= '1;
    end else begin
      for (int i = 0; i < PORTS; i++) state_q[i] <= state_d[i];
      pend_q   <= pend_d;
      ActLED_N <= led_d;
    end
  end

endmodule

// File: tb/tb_lan_act_blink.sv
// Self-checking bench for lan_act_blink with BLINK_HALF=4; the idle LED level follows
// the LAN_ACT_LINK_STEADY_EN build option.
module tb_lan_act_blink;

`ifdef LAN_ACT_LINK_STEADY_EN
  localparam logic IV = 1'b0;
`else
  localparam logic IV = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwrgd = 1'b0;
  logic [1:0] ract = 2'b11;
  logic [1:0] spd1 = 2'b11;
  logic [1:0] spd2 = 2'b11;
  logic [1:0] led;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q [$];

  typedef struct {
    logic       pwrgd;
    logic [1:0] spd1;
    logic [1:0] spd2;
    int         cycles;
    logic [1:0] exp;
  } vec_t;
  vec_t vecs [7];

  always #5 clk = ~clk;

  lan_act_blink #(.PORTS(2), .BLINK_HALF(4), .CW(3)) dut (
    .CLK32768 (clk),
    .RST_N    (rst_n),
    .ALL_PWRGD(pwrgd),
    .RActivity(ract),
    .Speed1R  (spd1),
    .Speed2R  (spd2),
    .ActLED_N (led)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_led(input int p, input logic v, input int lim, input string name);
    int n = 0;
    while (led[p] !== v && n < lim) begin
      step(1);
      n++;
    end
    chk(name, 32'(led[p]), 32'(v));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [1:0] e;
    logic       prev;
    logic       s [32];
    int odd, runs, p1bad, bad, trans, run, n;

    vecs[0] = '{1'b1, 2'b11, 2'b11, 100, 2'b11};
    vecs[1] = '{1'b1, 2'b10, 2'b11, 4,   {1'b1, IV}};
    vecs[2] = '{1'b0, 2'b10, 2'b11, 2,   2'b11};
    vecs[3] = '{1'b1, 2'b10, 2'b01, 4,   {IV, IV}};
    vecs[4] = '{1'b1, 2'b11, 2'b11, 4,   2'b11};
    vecs[5] = '{1'b1, 2'b00, 2'b00, 4,   {IV, IV}};
    vecs[6] = '{1'b1, 2'b01, 2'b11, 4,   {IV, 1'b1}};

    step(3);
    chk("reset_led", 32'(led), 32'(2'b11));
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      pwrgd = vecs[i].pwrgd;
      spd1  = vecs[i].spd1;
      spd2  = vecs[i].spd2;
      exp_q.push_back(vecs[i].exp);
      step(vecs[i].cycles);
      e = exp_q.pop_front();
      chk($sformatf("vec%0d", i), 32'(led), 32'(e));
    end

    // Single event: port 0 linked, port 1 unlinked.
    spd1 = 2'b10;
    spd2 = 2'b11;
    step(6);
    chk("single_pre", 32'(led), 32'({1'b1, IV}));
    ract[0] = 1'b0;
    step(2);
    ract[0] = 1'b1;
    odd = 0; runs = 0; p1bad = 0;
    prev = led[0];
    for (int k = 0; k < 40; k++) begin
      step(1);
      if (led[0] !== IV) odd++;
      if (led[0] !== IV && prev === IV) runs++;
      if (led[1] !== 1'b1) p1bad++;
      prev = led[0];
    end
    chk("single_len", 32'(odd), 32'd4);
    chk("single_runs", 32'(runs), 32'd1);
    chk("single_end", 32'(led[0]), 32'(IV));
    chk("single_port1", 32'(p1bad), 32'd0);

    // Continuous traffic on port 1.
    spd1 = 2'b00;
    step(6);
    for (int k = 0; k < 16; k++) begin
      ract[1] = ~ract[1];
      step(1);
    end
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      ract[1] = ~ract[1];
      step(1);
      s[k] = led[1];
      if (led[0] !== IV) bad++;
    end
    ract[1] = 1'b1;
    trans = 0;
    odd = 0;
    for (int k = 0; k < 31; k++) if (s[k+1] !== s[k]) trans++;
    for (int k = 0; k < 24; k++) if (s[k+4] === s[k]) odd++;
    chk("traffic_half", 32'(odd), 32'd0);
    chk("traffic_edges", 32'(trans >= 7 && trans <= 8), 32'd1);
    chk("traffic_port0", 32'(bad), 32'd0);
    run = 0; n = 0;
    while (run < 12 && n < 40) begin
      step(1);
      n++;
      run = (led[1] === IV) ? run + 1 : 0;
    end
    chk("traffic_stop", 32'(run), 32'd12);

    // Power fail just after a blink, with a fresh event pending.
    ract[0] = 1'b0;
    step(2);
    ract[0] = 1'b1;
    wait_led(0, ~IV, 20, "pf_blink_start");
    wait_led(0, 1'b0, 10, "pf_blink_on");
    ract[0] = 1'b0;
    step(1);
    ract[0] = 1'b1;
    step(3);
    pwrgd = 1'b0;
    step(2);
    chk("pf_led_off", 32'(led), 32'(2'b11));
    step(4);
    pwrgd = 1'b1;
    step(3);
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (led !== {IV, IV}) bad++;
    end
    chk("pf_no_blink", 32'(bad), 32'd0);

    // Asynchronous reset while an LED is lit.
    ract[0] = 1'b0;
    step(2);
    ract[0] = 1'b1;
    wait_led(0, 1'b0, 20, "rst_lit");
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'(led), 32'(2'b11));
    @(negedge clk);
    step(2);
    rst_n = 1'b1;
    step(6);
    chk("post_reset", 32'(led), 32'({IV, IV}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
